// File: rtl/aes_round_sequencer.sv
// Round-level control FSM for the AES-128 datapath: paces each round with the external
// period counter, drives per-stage enables and reports done/busy/timeout error.
module aes_round_sequencer #(
  parameter int unsigned NUM_ROUNDS = 10,
  parameter int unsigned ROUND_BITS = 4,
  parameter int unsigned TIMEOUT    = 63,
  parameter int unsigned TO_BITS    = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  done_flag,
  output logic                  count_enable,
  output logic [ROUND_BITS-1:0] round_num,
  output logic                  add_key_en,
  output logic                  sub_en,
  output logic                  shift_en,
  output logic                  mix_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {StIdle, StInit, StRun, StStep, StFinish, StError} state_e;

  localparam logic [ROUND_BITS-1:0] LastRound = ROUND_BITS'(NUM_ROUNDS);
  localparam logic [TO_BITS-1:0]    ToLast    = TO_BITS'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [ROUND_BITS-1:0] round_q, round_d;
  logic [TO_BITS-1:0]    to_q, to_d;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    to_d    = to_q;
    if (abort && state_q != StIdle) begin
      state_d = StIdle;
      round_d = '0;
      to_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StInit;
            round_d = '0;
            to_d    = '0;
          end
        end
        StInit: begin
          state_d = StRun;
          round_d = ROUND_BITS'(1);
          to_d    = '0;
        end
        StRun: begin
          to_d = to_q + TO_BITS'(1);
          // done_flag wins over a timeout landing in the same cycle
          if (done_flag) begin
            state_d = (round_q == LastRound) ? StFinish : StStep;
          end else if (to_q == ToLast) begin
            state_d = StError;
          end
        end
        StStep: begin
          state_d = StRun;
          round_d = round_q + ROUND_BITS'(1);
          to_d    = '0;
        end
        StFinish: state_d = StIdle;
        StError:  state_d = StError;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      round_q      <= '0;
      to_q         <= '0;
      count_enable <= 1'b0;
      add_key_en   <= 1'b0;
      sub_en       <= 1'b0;
      shift_en     <= 1'b0;
      mix_en       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      to_q         <= to_d;
      count_enable <= (state_d == StRun);
      add_key_en   <= (state_d == StInit) || (state_d == StRun);
      sub_en       <= (state_d == StRun);
      shift_en     <= (state_d == StRun);
      mix_en       <= (state_d == StRun) && (round_d != LastRound);
      busy         <= (state_d != StIdle) && (state_d != StError);
      done         <= (state_d == StFinish);
      error        <= (state_d == StError);
    end
  end

  assign round_num = round_q;

endmodule
